// File: rtl/debug_bridge_pkg.sv
// Shared constants for the debug byte bridge: source-mode encodings.
package debug_bridge_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_IDLE   = 2'd0;
    localparam logic [MODE_W-1:0] MODE_HB     = 2'd1;
    localparam logic [MODE_W-1:0] MODE_LOOP   = 2'd2;
    localparam logic [MODE_W-1:0] MODE_MIRROR = 2'd3;

endpackage

// File: rtl/debug_bridge_if.sv
// Bridge signal bundle: mode/clear control, UART rx pop, Ethernet snoop, UART tx stream and status.
interface debug_bridge_if
    import debug_bridge_pkg::*;
#(
    parameter int DW    = 8,
    parameter int CNT_W = 16,
    parameter int LVL_W = 5
) ();

    logic [MODE_W-1:0] i_mode;
    logic              i_clear;
    logic [DW-1:0]     i_uart_rdata;
    logic              i_uart_rready;
    logic              o_uart_rreq;
    logic [DW-1:0]     i_eth_sdata;
    logic              i_eth_svalid;
    logic [DW-1:0]     o_uart_wdata;
    logic              o_uart_wvalid;
    logic              i_uart_wready;
    logic [LVL_W-1:0]  o_fifo_level;
    logic [CNT_W-1:0]  o_drop_cnt;
    logic              o_overflow;

    // Bridge side.
    modport slave (
        input  i_mode, i_clear, i_uart_rdata, i_uart_rready, i_eth_sdata, i_eth_svalid,
               i_uart_wready,
        output o_uart_rreq, o_uart_wdata, o_uart_wvalid, o_fifo_level, o_drop_cnt, o_overflow
    );

    // Environment side.
    modport master (
        output i_mode, i_clear, i_uart_rdata, i_uart_rready, i_eth_sdata, i_eth_svalid,
               i_uart_wready,
        input  o_uart_rreq, o_uart_wdata, o_uart_wvalid, o_fifo_level, o_drop_cnt, o_overflow
    );

endinterface

// File: rtl/debug_fifo.sv
// Synchronous FIFO with flush; a write into a full FIFO succeeds when a read frees the slot on the same edge.
module debug_fifo #(
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 16,
    localparam int AW        = $clog2(FIFO_DEPTH),
    localparam int LW        = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          flush_i,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    output logic [DW-1:0] rd_data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o
);

    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          wr_ok, rd_ok;

    assign full_o    = (level_q == LW'(FIFO_DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign rd_data_o = mem[rptr_q];

    assign rd_ok = rd_en_i && !empty_o;
    assign wr_ok = wr_en_i && (!full_o || rd_ok);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (wr_ok) wptr_d = wptr_q + AW'(1);
        if (rd_ok) rptr_d = rptr_q + AW'(1);
        if (wr_ok && !rd_ok)      level_d = level_q + LW'(1);
        else if (rd_ok && !wr_ok) level_d = level_q - LW'(1);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst || flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_ok) mem[wptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/debug_bridge.sv
// Mode-selected byte source (heartbeat / UART loopback / Ethernet mirror) into a FIFO
// feeding a registered valid/ready stage toward the UART debug transmitter.
module debug_bridge
    import debug_bridge_pkg::*;
#(
    parameter int          DW         = 8,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [DW-1:0] HB_BYTE  = 8'hA5,
    parameter int          HB_PERIOD  = 1000,
    parameter int          CNT_W      = 16,
    localparam int         LVL_W      = $clog2(FIFO_DEPTH) + 1,
    localparam int         HB_W       = $clog2(HB_PERIOD)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    debug_bridge_if.slave bus
);

    logic [HB_W-1:0]  hb_cnt_q, hb_cnt_d;
    logic             rreq_q, rreq_d;
    logic             wvalid_q, wvalid_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             ovf_q, ovf_d;

    logic             hb_fire, load, can_wr, drop;
    logic             fifo_wr;
    logic [DW-1:0]    fifo_wdata, fifo_rdata;
    logic             fifo_full, fifo_empty;
    logic [LVL_W-1:0] fifo_level;

    debug_fifo #(.DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .flush_i   (bus.i_clear),
        .wr_en_i   (fifo_wr),
        .wr_data_i (fifo_wdata),
        .rd_en_i   (load),
        .rd_data_o (fifo_rdata),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level)
    );

    assign hb_fire = (bus.i_mode == MODE_HB) && (hb_cnt_q == HB_W'(HB_PERIOD - 1));
    assign load    = (!wvalid_q || bus.i_uart_wready) && !fifo_empty;
    assign can_wr  = !fifo_full || load;

    always_comb begin
        hb_cnt_d   = '0;
        fifo_wr    = 1'b0;
        fifo_wdata = bus.i_eth_sdata;
        drop       = 1'b0;
        if (bus.i_mode == MODE_HB && !hb_fire) hb_cnt_d = hb_cnt_q + HB_W'(1);

        // An issued rx pop always lands, even if the mode changed under it.
        if (rreq_q) begin
            fifo_wr    = 1'b1;
            fifo_wdata = bus.i_uart_rdata;
        end else begin
            case (bus.i_mode)
                MODE_HB: begin
                    fifo_wr    = hb_fire && can_wr;
                    fifo_wdata = HB_BYTE;
                end
                MODE_MIRROR: fifo_wr = bus.i_eth_svalid && can_wr;
                default: fifo_wr = 1'b0;
            endcase
        end
        drop = (bus.i_mode == MODE_MIRROR) && bus.i_eth_svalid && (rreq_q || !can_wr);

        rreq_d = (bus.i_mode == MODE_LOOP) && bus.i_uart_rready && !rreq_q && !fifo_full;

        wvalid_d = wvalid_q;
        wdata_d  = wdata_q;
        if (load) begin
            wvalid_d = 1'b1;
            wdata_d  = fifo_rdata;
        end else if (bus.i_uart_wready) begin
            wvalid_d = 1'b0;
        end

        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
        ovf_d = ovf_q || drop;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst || bus.i_clear) begin
            hb_cnt_q   <= '0;
            rreq_q     <= 1'b0;
            wvalid_q   <= 1'b0;
            wdata_q    <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            hb_cnt_q   <= hb_cnt_d;
            rreq_q     <= rreq_d;
            wvalid_q   <= wvalid_d;
            wdata_q    <= wdata_d;
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.o_uart_rreq   = rreq_q;
    assign bus.o_uart_wvalid = wvalid_q;
    assign bus.o_uart_wdata  = wdata_q;
    assign bus.o_fifo_level  = fifo_level;
    assign bus.o_drop_cnt    = drop_cnt_q;
    assign bus.o_overflow    = ovf_q;

endmodule

// File: tb/tb_debug_bridge.sv
// Directed bench for debug_bridge: expected tx bytes queued at stimulus time, popped on each transfer.
module tb_debug_bridge;
    import debug_bridge_pkg::*;

    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam int CNT_W = 16;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic i_clk;
    logic i_rst;
    int   checks = 0;
    int   errors = 0;
    logic [DW-1:0] sb [$];

    int   rx_idx = 0;
    logic rx_en = 1'b0;
    logic prev_rreq = 1'b0;

    debug_bridge_if #(.DW(DW), .CNT_W(CNT_W), .LVL_W(LVL_W)) bus ();

    debug_bridge #(
        .DW(DW), .FIFO_DEPTH(DEPTH), .HB_BYTE(8'hA5), .HB_PERIOD(10), .CNT_W(CNT_W)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Upstream UART rx holding bytes 0x01..0x20.
    assign bus.i_uart_rready = rx_en && (rx_idx < 32);
    assign bus.i_uart_rdata  = DW'(rx_idx + 1);
    always @(posedge i_clk) if (bus.o_uart_rreq && rx_idx < 32) rx_idx <= rx_idx + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    always @(negedge i_clk) begin
        logic [31:0] exp;
        if (i_rst && bus.o_uart_wvalid && bus.i_uart_wready) begin
            exp = (sb.size() != 0) ? 32'(sb.pop_front()) : 'x;
            chk("tx_data", 32'(bus.o_uart_wdata), exp);
        end
        if (bus.o_uart_rreq) chk("rreq_single", 32'(prev_rreq), 32'd0);
        prev_rreq = bus.o_uart_rreq;
    end

    initial begin
        logic done;
        i_rst = 1'b0;
        bus.i_mode = MODE_HB;
        bus.i_clear = 1'b0;
        bus.i_eth_sdata = '0;
        bus.i_eth_svalid = 1'b0;
        bus.i_uart_wready = 1'b1;
        step(3);
        chk("rst_wvalid", 32'(bus.o_uart_wvalid), 0);
        chk("rst_wdata", 32'(bus.o_uart_wdata), 0);
        chk("rst_level", 32'(bus.o_fifo_level), 0);
        chk("rst_drop", 32'(bus.o_drop_cnt), 0);
        chk("rst_ovf", 32'(bus.o_overflow), 0);
        chk("rst_rreq", 32'(bus.o_uart_rreq), 0);

        // Heartbeat: written on edge 10, valid after edge 11, then every 10 cycles.
        i_rst = 1'b1;
        sb.push_back(8'hA5);
        sb.push_back(8'hA5);
        step(10);
        chk("hb_level_e10", 32'(bus.o_fifo_level), 1);
        chk("hb_wvalid_e10", 32'(bus.o_uart_wvalid), 0);
        step(1);
        chk("hb_wvalid_e11", 32'(bus.o_uart_wvalid), 1);
        chk("hb_wdata_e11", 32'(bus.o_uart_wdata), 32'hA5);
        step(1);
        chk("hb_wvalid_e12", 32'(bus.o_uart_wvalid), 0);
        step(8);
        chk("hb_wvalid_e20", 32'(bus.o_uart_wvalid), 0);
        step(1);
        chk("hb_wvalid_e21", 32'(bus.o_uart_wvalid), 1);
        bus.i_mode = MODE_IDLE;
        step(3);
        chk("hb_sb_empty", 32'(sb.size()), 0);

        // UART loopback under backpressure: 16 in FIFO + 1 in output stage.
        for (int i = 1; i <= 32; i++) sb.push_back(DW'(i));
        bus.i_uart_wready = 1'b0;
        bus.i_mode = MODE_LOOP;
        rx_en = 1'b1;
        step(100);
        chk("loop_pops", 32'(rx_idx), 17);
        chk("loop_level", 32'(bus.o_fifo_level), 16);
        chk("loop_wvalid", 32'(bus.o_uart_wvalid), 1);
        chk("loop_wdata", 32'(bus.o_uart_wdata), 32'h01);
        bus.i_uart_wready = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            step(1);
            done = (rx_idx == 32) && (bus.o_fifo_level == 0) && !bus.o_uart_wvalid && !bus.o_uart_rreq;
        end
        chk("loop_drain_done", 32'(done), 1);
        chk("loop_sb_empty", 32'(sb.size()), 0);
        rx_en = 1'b0;
        bus.i_mode = MODE_IDLE;

        // Idle ignores strobes.
        bus.i_eth_svalid = 1'b1;
        bus.i_eth_sdata = 8'hEE;
        step(3);
        bus.i_eth_svalid = 1'b0;
        step(1);
        chk("idle_level", 32'(bus.o_fifo_level), 0);
        chk("idle_wvalid", 32'(bus.o_uart_wvalid), 0);

        // Mirror: 20 strobes with wready low -> 17 held, 3 dropped.
        bus.i_uart_wready = 1'b0;
        bus.i_mode = MODE_MIRROR;
        for (int i = 0; i < 20; i++) begin
            bus.i_eth_svalid = 1'b1;
            bus.i_eth_sdata = DW'(8'h40 + i);
            if (i < 17) sb.push_back(DW'(8'h40 + i));
            step(1);
        end
        bus.i_eth_svalid = 1'b0;
        chk("mir_level", 32'(bus.o_fifo_level), 16);
        chk("mir_drop", 32'(bus.o_drop_cnt), 3);
        chk("mir_ovf", 32'(bus.o_overflow), 1);
        chk("mir_wdata", 32'(bus.o_uart_wdata), 32'h40);

        // Back-to-back drain: valid continuously high for 17 cycles.
        bus.i_mode = MODE_IDLE;
        bus.i_uart_wready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            chk("b2b_wvalid", 32'(bus.o_uart_wvalid), 1);
            step(1);
        end
        chk("b2b_end_wvalid", 32'(bus.o_uart_wvalid), 0);
        chk("b2b_sb_empty", 32'(sb.size()), 0);

        // Clear with FIFO at 5 and a same-cycle strobe.
        bus.i_uart_wready = 1'b0;
        bus.i_mode = MODE_MIRROR;
        for (int i = 0; i < 6; i++) begin
            bus.i_eth_svalid = 1'b1;
            bus.i_eth_sdata = DW'(8'h60 + i);
            step(1);
        end
        chk("clr_pre_level", 32'(bus.o_fifo_level), 5);
        bus.i_eth_sdata = 8'h99;
        bus.i_clear = 1'b1;
        step(1);
        bus.i_clear = 1'b0;
        bus.i_eth_svalid = 1'b0;
        chk("clr_level", 32'(bus.o_fifo_level), 0);
        chk("clr_wvalid", 32'(bus.o_uart_wvalid), 0);
        chk("clr_wdata", 32'(bus.o_uart_wdata), 0);
        chk("clr_drop", 32'(bus.o_drop_cnt), 0);
        chk("clr_ovf", 32'(bus.o_overflow), 0);
        bus.i_mode = MODE_IDLE;
        bus.i_uart_wready = 1'b1;
        step(3);
        chk("clr_post_wvalid", 32'(bus.o_uart_wvalid), 0);

        // Reset while a byte is held and the FIFO is full with one drop.
        bus.i_uart_wready = 1'b0;
        bus.i_mode = MODE_MIRROR;
        for (int i = 0; i < 18; i++) begin
            bus.i_eth_svalid = 1'b1;
            bus.i_eth_sdata = DW'(8'h70 + i);
            step(1);
        end
        bus.i_eth_svalid = 1'b0;
        chk("prerst_drop", 32'(bus.o_drop_cnt), 1);
        chk("prerst_wvalid", 32'(bus.o_uart_wvalid), 1);
        i_rst = 1'b0;
        step(1);
        chk("mrst_wvalid", 32'(bus.o_uart_wvalid), 0);
        chk("mrst_wdata", 32'(bus.o_uart_wdata), 0);
        chk("mrst_level", 32'(bus.o_fifo_level), 0);
        chk("mrst_drop", 32'(bus.o_drop_cnt), 0);
        chk("mrst_ovf", 32'(bus.o_overflow), 0);
        chk("mrst_rreq", 32'(bus.o_uart_rreq), 0);
        i_rst = 1'b1;
        bus.i_mode = MODE_IDLE;
        bus.i_uart_wready = 1'b1;
        step(3);
        chk("final_wvalid", 32'(bus.o_uart_wvalid), 0);
        chk("final_sb_empty", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
